// File: rtl/parity_serial_tx.sv
// Serial transmitter for 11-bit frames: start, 8 data bits LSB first, parity, stop.
// Each bit is held for CLKS_PER_BIT clocks; tx idles high and comes straight from a flop.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | driving start bit (0)
// DATA   | driving data bit data_idx from the shift register
// PARITY | driving the captured parity bit
// STOP   | driving stop bit (1)
module parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] D,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    data_idx;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic          bit_done;

  assign bit_done = (bit_cnt == CNT_LAST);
  assign ready    = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // tx is loaded with the next bit value on the same edge that ends the current bit,
  // so the line changes exactly at bit boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      bit_cnt    <= '0;
      data_idx   <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (valid) begin
            shift_reg  <= D;
            parity_reg <= (^D) ^ ODD_BIT;
            tx         <= 1'b0;
            bit_cnt    <= '0;
            data_idx   <= '0;
            state      <= START;
          end
        end

        START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            tx      <= shift_reg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (data_idx == 3'd7) begin
              tx    <= parity_reg;
              state <= PARITY;
            end else begin
              data_idx  <= data_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_done) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          tx      <= 1'b1;
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx: even/odd parity at 4 clocks per bit and even at 1 clock per bit.
module tb_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic       r0, r1, r2;
  logic       t0, t1, t2;
  logic       b0, b1, b2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  parity_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .D(d0), .valid(v0), .ready(r0), .tx(t0), .busy(b0));
  parity_serial_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .D(d1), .valid(v1), .ready(r1), .tx(t1), .busy(b1));
  parity_serial_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(0)) u_fast (
    .clk(clk), .rst(rst), .D(d2), .valid(v2), .ready(r2), .tx(t2), .busy(b2));

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic get_tx(input int i);
    case (i)
      0: return t0;
      1: return t1;
      default: return t2;
    endcase
  endfunction

  function automatic logic get_busy(input int i);
    case (i)
      0: return b0;
      1: return b1;
      default: return b2;
    endcase
  endfunction

  function automatic logic get_ready(input int i);
    case (i)
      0: return r0;
      1: return r1;
      default: return r2;
    endcase
  endfunction

  function automatic int cpb_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  task automatic set_in(input int i, input logic v, input logic [7:0] d);
    case (i)
      0: begin v0 = v; d0 = d; end
      1: begin v1 = v; d1 = d; end
      default: begin v2 = v; d2 = d; end
    endcase
  endtask

  // Samples the 11 bits of a frame starting at the next falling edge.
  task automatic check_frame(input int i, input logic [7:0] d, input logic par,
                             input string nm, input bit disturb);
    logic [10:0] fr;
    logic        seen;
    logic        busy_seen;
    int          cpb;
    fr = {1'b1, par, d, 1'b0};
    cpb = cpb_of(i);
    busy_seen = 1'b1;
    for (int b = 0; b < 11; b++) begin
      seen = fr[b];
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (get_tx(i) !== fr[b]) seen = get_tx(i);
        if (get_busy(i) !== 1'b1) busy_seen = get_busy(i);
        if (disturb && b >= 1 && b <= 8) set_in(i, c[0], ~d ^ 8'(c + b));
      end
      chk($sformatf("%s bit%0d", nm, b), seen, fr[b]);
    end
    chk($sformatf("%s busy", nm), busy_seen, 1'b1);
    if (disturb) set_in(i, 1'b0, d);
  endtask

  task automatic run_frame(input int i, input logic [7:0] d, input logic par, input string nm);
    @(negedge clk);
    chk($sformatf("%s ready", nm), get_ready(i), 1'b1);
    set_in(i, 1'b1, d);
    @(posedge clk);
    #1 set_in(i, 1'b0, ~d);
    check_frame(i, d, par, nm, 1'b0);
    @(negedge clk);
    chk($sformatf("%s idle tx", nm), get_tx(i), 1'b1);
    chk($sformatf("%s idle busy", nm), get_busy(i), 1'b0);
  endtask

  initial begin
    vecs[0] = '{0, 8'h00, 1'b0};
    vecs[1] = '{0, 8'h01, 1'b1};
    vecs[2] = '{0, 8'hFF, 1'b0};
    vecs[3] = '{1, 8'hAA, 1'b1};
    vecs[4] = '{1, 8'hF0, 1'b1};
    vecs[5] = '{1, 8'h80, 1'b0};
    vecs[6] = '{0, 8'h7E, 1'b0};
    vecs[7] = '{2, 8'h13, 1'b1};
    vecs[8] = '{2, 8'hA5, 1'b0};
    vecs[9] = '{2, 8'h00, 1'b0};

    rst = 1'b1;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);

    // valid offered while in reset must not be taken
    @(negedge clk);
    v0 = 1'b1; d0 = 8'h5A;
    @(negedge clk);
    chk("reset tx0", t0, 1'b1);
    chk("reset busy0", b0, 1'b0);
    chk("reset ready0", r0, 1'b0);
    chk("reset tx1", t1, 1'b1);
    chk("reset tx2", t2, 1'b1);
    @(negedge clk);
    v0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post reset busy0", b0, 1'b0);
    chk("post reset tx0", t0, 1'b1);
    chk("post reset ready0", r0, 1'b1);
    chk("post reset ready2", r2, 1'b1);

    for (int k = 0; k < 10; k++)
      run_frame(vecs[k].inst, vecs[k].data, vecs[k].par, $sformatf("vec%0d", k));

    // Back-to-back with valid held high; D changes while busy must not matter
    @(negedge clk);
    set_in(0, 1'b1, 8'h03);
    @(posedge clk);
    #1 d0 = 8'hFF;
    check_frame(0, 8'h03, 1'b0, "b2b first", 1'b0);
    @(negedge clk);
    chk("b2b gap tx", t0, 1'b1);
    chk("b2b gap busy", b0, 1'b0);
    chk("b2b gap ready", r0, 1'b1);
    @(posedge clk);
    #1 v0 = 1'b0;
    check_frame(0, 8'hFF, 1'b0, "b2b second", 1'b0);
    @(negedge clk);
    chk("b2b end tx", t0, 1'b1);
    chk("b2b end busy", b0, 1'b0);

    // D and valid wiggled during the data bits of 8'h55
    @(negedge clk);
    set_in(0, 1'b1, 8'h55);
    @(posedge clk);
    #1 set_in(0, 1'b0, 8'h55);
    check_frame(0, 8'h55, 1'b0, "mid", 1'b1);
    set_in(0, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid no extra tx %0d", k), t0, 1'b1);
      chk($sformatf("mid no extra busy %0d", k), b0, 1'b0);
    end

    // Reset asserted on cycle 20 of a frame
    @(negedge clk);
    set_in(0, 1'b1, 8'hC3);
    @(posedge clk);
    #1 set_in(0, 1'b0, 8'h00);
    repeat (20) @(negedge clk);
    chk("pre abort busy", b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("abort tx", t0, 1'b1);
    chk("abort busy", b0, 1'b0);
    chk("abort ready", r0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("abort hold tx", t0, 1'b1);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort after tx %0d", k), t0, 1'b1);
      chk($sformatf("abort after busy %0d", k), b0, 1'b0);
    end
    run_frame(0, 8'h3C, 1'b0, "after abort");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
